// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU result FIFO and its producer/consumer.
// The out_zero/out_neg flag signals exist only when ALU_RESULT_FLAGS_EN is defined.
interface alu_result_fifo_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [2:0]       in_opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_opcode;
  logic [CNT_W-1:0] count;
  logic             illegal_err;
  logic             err_clr;
`ifdef ALU_RESULT_FLAGS_EN
  logic             out_zero;
  logic             out_neg;
`endif

  modport master (
    output in_valid, in_result, in_opcode, out_ready, err_clr,
    input  in_ready, out_valid, out_result, out_opcode, count, illegal_err
`ifdef ALU_RESULT_FLAGS_EN
    , input out_zero, out_neg
`endif
  );

  modport slave (
    input  in_valid, in_result, in_opcode, out_ready, err_clr,
    output in_ready, out_valid, out_result, out_opcode, count, illegal_err
`ifdef ALU_RESULT_FLAGS_EN
    , output out_zero, out_neg
`endif
  );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO buffering ALU results with their opcodes; screens illegal opcodes.
// Optional per-entry zero/negative flags are enabled by defining ALU_RESULT_FLAGS_EN.
module alu_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  alu_result_fifo_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  logic [WIDTH-1:0] mem_result [DEPTH];
  logic [2:0]       mem_opcode [DEPTH];
`ifdef ALU_RESULT_FLAGS_EN
  logic             mem_zero   [DEPTH];
  logic             mem_neg    [DEPTH];
`endif

  logic full_c;
  logic empty_c;
  logic legal_c;
  logic accept_c;
  logic push_c;
  logic pop_c;

  // Illegal opcodes are still consumed when accepted, they just never enter storage.
  assign full_c   = (count_q == CNT_W'(DEPTH));
  assign empty_c  = (count_q == '0);
  assign legal_c  = ~(bus.in_opcode[2] & bus.in_opcode[1]);
  assign accept_c = bus.in_valid & ~full_c;
  assign push_c   = accept_c & legal_c;
  assign pop_c    = ~empty_c & bus.out_ready;

  assign bus.in_ready  = ~full_c;
  assign bus.out_valid = ~empty_c;
  assign bus.count     = count_q;
  assign bus.illegal_err = err_q;

  // Pointer, occupancy and sticky error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (accept_c && !legal_c) err_q <= 1'b1;
      else if (bus.err_clr)     err_q <= 1'b0;
    end
  end

  // Storage carries no reset; occupancy alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_result[wr_ptr] <= bus.in_result;
      mem_opcode[wr_ptr] <= bus.in_opcode;
`ifdef ALU_RESULT_FLAGS_EN
      mem_zero[wr_ptr]   <= (bus.in_result == '0);
      mem_neg[wr_ptr]    <= bus.in_result[WIDTH-1];
`endif
    end
  end

  // Head entry is presented directly and forced to zero while empty.
  always_comb begin
    bus.out_result = '0;
    bus.out_opcode = '0;
`ifdef ALU_RESULT_FLAGS_EN
    bus.out_zero   = 1'b0;
    bus.out_neg    = 1'b0;
`endif
    if (!empty_c) begin
      bus.out_result = mem_result[rd_ptr];
      bus.out_opcode = mem_opcode[rd_ptr];
`ifdef ALU_RESULT_FLAGS_EN
      bus.out_zero   = mem_zero[rd_ptr];
      bus.out_neg    = mem_neg[rd_ptr];
`endif
    end
  end
endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: vector table plus hand sequences for wrap, reset and flags.
module tb_alu_result_fifo;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned NVEC  = 17;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_result_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  alu_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] ires;
    logic [2:0]  iop;
    logic        ordy;
    logic        eclr;
    logic        ov;
    logic [15:0] ores;
    logic [2:0]  oop;
    logic [2:0]  cnt;
    logic        ir;
    logic        err;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic iv, input logic [15:0] ires, input logic [2:0] iop,
                              input logic ordy, input logic eclr, input logic ov,
                              input logic [15:0] ores, input logic [2:0] oop,
                              input logic [2:0] cnt, input logic ir, input logic err);
    vec_t v;
    v.iv = iv; v.ires = ires; v.iop = iop; v.ordy = ordy; v.eclr = eclr;
    v.ov = ov; v.ores = ores; v.oop = oop; v.cnt = cnt; v.ir = ir; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] r, input logic [2:0] op,
                       input logic ordy, input logic eclr);
    bus.in_valid  = iv;
    bus.in_result = r;
    bus.in_opcode = op;
    bus.out_ready = ordy;
    bus.err_clr   = eclr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic [15:0] ores,
                         input logic [2:0] oop, input logic [2:0] cnt, input logic ir,
                         input logic err);
    chk({tag, ".out_valid"},   32'(bus.out_valid),   32'(ov));
    chk({tag, ".out_result"},  32'(bus.out_result),  32'(ores));
    chk({tag, ".out_opcode"},  32'(bus.out_opcode),  32'(oop));
    chk({tag, ".count"},       32'(bus.count),       32'(cnt));
    chk({tag, ".in_ready"},    32'(bus.in_ready),    32'(ir));
    chk({tag, ".illegal_err"}, 32'(bus.illegal_err), 32'(err));
  endtask

  logic [18:0] q [$];
  logic [15:0] d;
  logic [2:0]  op;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);

    //                iv  ires      iop   ordy  eclr  ov  ores      oop   cnt   ir  err
    vecs[0]  = mk(1, 16'h0003, 3'd0, 0, 0, 1, 16'h0003, 3'd0, 3'd1, 1, 0);
    vecs[1]  = mk(1, 16'h0011, 3'd1, 0, 0, 1, 16'h0003, 3'd0, 3'd2, 1, 0);
    vecs[2]  = mk(1, 16'h0022, 3'd2, 0, 0, 1, 16'h0003, 3'd0, 3'd3, 1, 0);
    vecs[3]  = mk(1, 16'h0033, 3'd3, 0, 0, 1, 16'h0003, 3'd0, 3'd4, 0, 0);
    vecs[4]  = mk(1, 16'h0044, 3'd4, 0, 0, 1, 16'h0003, 3'd0, 3'd4, 0, 0);
    vecs[5]  = mk(1, 16'h0044, 3'd4, 1, 0, 1, 16'h0011, 3'd1, 3'd3, 1, 0);
    vecs[6]  = mk(1, 16'h0044, 3'd4, 1, 0, 1, 16'h0022, 3'd2, 3'd3, 1, 0);
    vecs[7]  = mk(0, 16'h0000, 3'd0, 1, 0, 1, 16'h0033, 3'd3, 3'd2, 1, 0);
    vecs[8]  = mk(0, 16'h0000, 3'd0, 1, 0, 1, 16'h0044, 3'd4, 3'd1, 1, 0);
    vecs[9]  = mk(0, 16'h0000, 3'd0, 1, 0, 0, 16'h0000, 3'd0, 3'd0, 1, 0);
    vecs[10] = mk(0, 16'h0000, 3'd0, 1, 0, 0, 16'h0000, 3'd0, 3'd0, 1, 0);
    vecs[11] = mk(1, 16'h1234, 3'd6, 0, 0, 0, 16'h0000, 3'd0, 3'd0, 1, 1);
    vecs[12] = mk(0, 16'h0000, 3'd0, 0, 1, 0, 16'h0000, 3'd0, 3'd0, 1, 0);
    vecs[13] = mk(1, 16'h5555, 3'd7, 0, 1, 0, 16'h0000, 3'd0, 3'd0, 1, 1);
    vecs[14] = mk(1, 16'h0AAA, 3'd5, 0, 0, 1, 16'h0AAA, 3'd5, 3'd1, 1, 1);
    vecs[15] = mk(0, 16'h0000, 3'd0, 0, 1, 1, 16'h0AAA, 3'd5, 3'd1, 1, 0);
    vecs[16] = mk(1, 16'hFFFF, 3'd6, 1, 0, 0, 16'h0000, 3'd0, 3'd0, 1, 1);

    tick;
    tick;
    chk_all("reset", 1'b0, 16'h0, 3'd0, 3'd0, 1'b1, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i].iv, vecs[i].ires, vecs[i].iop, vecs[i].ordy, vecs[i].eclr);
      tick;
      chk_all($sformatf("v%0d", i), vecs[i].ov, vecs[i].ores, vecs[i].oop,
              vecs[i].cnt, vecs[i].ir, vecs[i].err);
    end

    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b1);
    tick;
    chk("clr.illegal_err", 32'(bus.illegal_err), 32'd0);

    // Steady push+pop at depth 2 long enough to wrap both pointers twice.
    for (int i = 0; i < 12; i++) begin
      d  = 16'h1000 + 16'(i);
      op = 3'(i % 6);
      drive(1'b1, d, op, (i >= 2), 1'b0);
      tick;
      if (i >= 2) void'(q.pop_front());
      q.push_back({op, d});
      chk($sformatf("stream%0d.count", i), 32'(bus.count), (i == 0) ? 32'd1 : 32'd2);
      chk($sformatf("stream%0d.head", i), {13'd0, bus.out_opcode, bus.out_result}, 32'(q[0]));
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
      tick;
      void'(q.pop_front());
      if (q.size() > 0)
        chk($sformatf("drain%0d.head", i), {13'd0, bus.out_opcode, bus.out_result}, 32'(q[0]));
    end
    chk_all("drained", 1'b0, 16'h0, 3'd0, 3'd0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a cycle with three entries held.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0700 + 16'(i), 3'd1, 1'b0, 1'b0);
      tick;
    end
    chk("prerst.count", 32'(bus.count), 32'd3);
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("midrst", 1'b0, 16'h0, 3'd0, 3'd0, 1'b1, 1'b0);
    tick;
    rst_n = 1'b1;
    drive(1'b1, 16'h0BEE, 3'd2, 1'b0, 1'b0);
    tick;
    chk_all("postrst.push", 1'b1, 16'h0BEE, 3'd2, 3'd1, 1'b1, 1'b0);
    drive(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
    tick;
    chk_all("postrst.pop", 1'b0, 16'h0, 3'd0, 3'd0, 1'b1, 1'b0);

`ifdef ALU_RESULT_FLAGS_EN
    chk("flags.empty_zero", 32'(bus.out_zero), 32'd0);
    chk("flags.empty_neg",  32'(bus.out_neg),  32'd0);
    drive(1'b1, 16'h0000, 3'd1, 1'b0, 1'b0);
    tick;
    drive(1'b1, 16'h8001, 3'd1, 1'b0, 1'b0);
    tick;
    chk("flags.a_zero", 32'(bus.out_zero), 32'd1);
    chk("flags.a_neg",  32'(bus.out_neg),  32'd0);
    drive(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
    tick;
    chk("flags.b_zero", 32'(bus.out_zero), 32'd0);
    chk("flags.b_neg",  32'(bus.out_neg),  32'd1);
    chk("flags.b_result", 32'(bus.out_result), 32'h8001);
    tick;
    chk("flags.drained_neg", 32'(bus.out_neg), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
